// File: rtl/elc3_mmio_controller.sv
// eLC-3 memory control unit: SRAM strobes, keyboard FIFO, display handshake and halt decode.
// Optional keyboard interrupt (KBSR IE bit and registered KB_IRQ) enabled by defining ELC3_KB_IRQ_EN.
module elc3_mmio_controller #(
    parameter int          DATA_W    = 16,
    parameter int          KB_DEPTH  = 8,
    parameter logic [15:0] IO_BASE   = 16'hFE00,
    parameter logic [15:0] HALT_ADDR = 16'hFFFF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MIO_EN,
    input  logic              R_W,
    input  logic [15:0]       Address,
    input  logic [DATA_W-1:0] Data_FromCPU,
    input  logic [DATA_W-1:0] Data_FromSRAM,
    input  logic [DATA_W-1:0] Data_FromKeyboard,
    input  logic              Keypress,
    input  logic              DisplayReady,
    output logic [DATA_W-1:0] Data_ToCPU,
    output logic [DATA_W-1:0] Data_ToSRAM,
    output logic [DATA_W-1:0] Data_ToVideo,
    output logic              DisplayWE,
    output logic              Mem_CE,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic              Mem_LB,
    output logic              Mem_UB,
    output logic              DoHalt,
    output logic              KB_IRQ
);

    localparam int PTR_W = $clog2(KB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [15:0] KBSR_ADDR = IO_BASE;
    localparam logic [15:0] KBDR_ADDR = IO_BASE + 16'd2;
    localparam logic [15:0] DSR_ADDR  = IO_BASE + 16'd4;
    localparam logic [15:0] DDR_ADDR  = IO_BASE + 16'd6;

    logic [DATA_W-1:0] fifo_mem [KB_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] ddr_q, ddr_d;
    logic              dwe_q, dwe_d;
    logic              ie_val;

    logic hit_kbsr, hit_kbdr, hit_dsr, hit_ddr, hit_halt, sram_sel;
    logic rd_kbdr, wr_kbsr, ddr_accept;
    logic fifo_empty, fifo_full;
    logic push_req, do_pop, do_push;
    logic [DATA_W-1:0] fifo_head, kbsr_val, dsr_val;

    assign hit_kbsr = (Address == KBSR_ADDR);
    assign hit_kbdr = (Address == KBDR_ADDR);
    assign hit_dsr  = (Address == DSR_ADDR);
    assign hit_ddr  = (Address == DDR_ADDR);
    assign hit_halt = (Address == HALT_ADDR);
    // Unmapped addresses inside the I/O window fall through to SRAM.
    assign sram_sel = MIO_EN && !(hit_kbsr || hit_kbdr || hit_dsr || hit_ddr || hit_halt);

    assign Mem_CE      = 1'b1;
    assign Mem_LB      = 1'b1;
    assign Mem_UB      = 1'b1;
    assign Mem_WE      = sram_sel && R_W;
    assign Mem_OE      = sram_sel && !R_W;
    assign Data_ToSRAM = Data_FromCPU;
    assign DoHalt      = MIO_EN && R_W && hit_halt;

    assign rd_kbdr    = MIO_EN && !R_W && hit_kbdr;
    assign wr_kbsr    = MIO_EN && R_W && hit_kbsr;
    assign ddr_accept = MIO_EN && R_W && hit_ddr && ready_q;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(KB_DEPTH));
    assign fifo_head  = fifo_empty ? '0 : fifo_mem[rd_ptr_q];

    // A full FIFO still accepts a key when the head leaves in the same cycle.
    assign push_req = Keypress && (Data_FromKeyboard != '0);
    assign do_pop   = rd_kbdr && !fifo_empty;
    assign do_push  = push_req && (!fifo_full || do_pop);

    always_comb begin
        kbsr_val     = '0;
        kbsr_val[15] = !fifo_empty;
        kbsr_val[14] = ie_val;
        kbsr_val[13] = ovf_q;
        dsr_val      = '0;
        dsr_val[15]  = ready_q;
    end

    always_comb begin
        Data_ToCPU = Data_FromSRAM;
        if (MIO_EN && !R_W) begin
            if (hit_kbsr)      Data_ToCPU = kbsr_val;
            else if (hit_kbdr) Data_ToCPU = fifo_head;
            else if (hit_dsr)  Data_ToCPU = dsr_val;
            else if (hit_ddr)  Data_ToCPU = ddr_q;
        end
    end

    always_comb begin
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;

        // A same-cycle overflow event wins over a software clear.
        ovf_d = ovf_q;
        if (wr_kbsr && Data_FromCPU[13]) ovf_d = 1'b0;
        if (push_req && fifo_full && !do_pop) ovf_d = 1'b1;

        ready_d = ready_q;
        if (DisplayReady) ready_d = 1'b1;
        if (ddr_accept)   ready_d = 1'b0;

        ddr_d = ddr_accept ? Data_FromCPU : ddr_q;
        dwe_d = ddr_accept;
    end

    always_ff @(posedge Clk) begin
        if (do_push) fifo_mem[wr_ptr_q] <= Data_FromKeyboard;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            ready_q  <= 1'b0;
            ddr_q    <= '0;
            dwe_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            ready_q  <= ready_d;
            ddr_q    <= ddr_d;
            dwe_q    <= dwe_d;
        end
    end

    assign Data_ToVideo = ddr_q;
    assign DisplayWE    = dwe_q;

`ifdef ELC3_KB_IRQ_EN
    logic ie_q, ie_d, irq_q, irq_d;

    assign ie_d  = wr_kbsr ? Data_FromCPU[14] : ie_q;
    assign irq_d = ie_q && !fifo_empty;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            ie_q  <= ie_d;
            irq_q <= irq_d;
        end
    end

    assign ie_val = ie_q;
    assign KB_IRQ = irq_q;
`else
    assign ie_val = 1'b0;
    assign KB_IRQ = 1'b0;
`endif

endmodule

// File: doc/elc3_mmio_controller.md
Name: elc3_mmio_controller

Overview:
- Parametrised next-generation memory control unit for the eLC-3.
- Decodes CPU memory accesses into SRAM strobes or memory-mapped I/O registers.
- Adds a keyboard receive FIFO with overflow tracking, a display write handshake that drops writes issued while the display is busy, and a configurable I/O base address.
- Sits between the CPU memory interface, the SRAM chip, the keyboard decoder and the video/text output.

Parameters:
- DATA_W, 16, width of CPU, SRAM, keyboard and video data paths.
- KB_DEPTH, 8, keyboard FIFO entries; power of two, 2 to 64.
- IO_BASE, 16'hFE00, base address of the I/O register window.
- HALT_ADDR, 16'hFFFF, address whose write asserts DoHalt.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- MIO_EN  in  1  memory access valid this cycle.
- R_W  in  1  1 = write, 0 = read.
- Address  in  16  access address.
- Data_FromCPU  in  DATA_W  write data.
- Data_FromSRAM  in  DATA_W  SRAM read data.
- Data_FromKeyboard  in  DATA_W  key code.
- Keypress  in  1  one-cycle key-valid strobe.
- DisplayReady  in  1  display can accept a character (level).
- Data_ToCPU  out  DATA_W  read data mux output.
- Data_ToSRAM  out  DATA_W  equals Data_FromCPU.
- Data_ToVideo  out  DATA_W  DDR contents.
- DisplayWE  out  1  registered one-cycle display write pulse.
- Mem_CE, Mem_OE, Mem_WE, Mem_LB, Mem_UB  out  1 each  SRAM strobes, active-high.
- DoHalt  out  1  combinational halt request.
- KB_IRQ  out  1  keyboard interrupt; tied 0 unless ELC3_KB_IRQ_EN is defined.

Behaviour:
- Register map (decode only when MIO_EN=1):
  - IO_BASE+0: KBSR.
  - IO_BASE+2: KBDR.
  - IO_BASE+4: DSR.
  - IO_BASE+6: DDR.
  - HALT_ADDR: halt.
  - Every other address goes to SRAM.
  - Any other address in the I/O window is treated as SRAM.
- SRAM access:
  - Mem_CE, Mem_LB and Mem_UB are constant 1.
  - Mem_WE = MIO_EN & R_W; Mem_OE = MIO_EN & !R_W; both combinational, only for SRAM addresses.
  - Data_ToCPU = Data_FromSRAM whenever no I/O read is selected.
- KBSR read value:
  - [15] = FIFO non-empty.
  - [14] = IE (0 without the optional feature).
  - [13] = sticky overflow.
  - All other bits 0.
- KBSR write: 1 in bit 13 clears overflow; bit 14 loads IE when the feature is present. Other bits are ignored.
- KBDR read:
  - Data_ToCPU = FIFO head, combinational.
  - If non-empty, the head pops at the end of the cycle.
  - If empty, reads 0 and nothing pops.
  - Writes to KBDR are ignored.
- Keyboard push:
  - Pushes on Keypress=1 with Data_FromKeyboard != 0; zero codes are discarded.
  - If the FIFO is full with no pop in the same cycle, the key is dropped and overflow is set.
  - Full with a simultaneous pop: both occur, occupancy unchanged, no overflow.
  - Empty with a simultaneous push and KBDR read: read returns 0, the push is stored, no pop.
- FIFO implementation:
  - Read/write pointers are log2(KB_DEPTH) bits and wrap modulo KB_DEPTH.
  - Count is log2(KB_DEPTH)+1 bits.
- DSR:
  - [15] = ready; all other bits read 0.
  - Ready sets on any cycle with DisplayReady=1.
  - Ready clears on an accepted DDR write; clear wins over a same-cycle set.
- DDR write, display ready:
  - DDR loads Data_FromCPU and ready clears.
  - DisplayWE = 1 exactly one cycle later, for one cycle.
- DDR write, display not ready: the write is dropped, with no DDR change and no pulse.
- Data_ToVideo = DDR.
- DoHalt = MIO_EN & R_W & (Address == HALT_ADDR).
- Reset values, applied asynchronously:
  - FIFO empty, pointers and count 0.
  - Overflow 0, IE 0, DSR ready 0, DDR 0.
  - DisplayWE 0, KB_IRQ 0.
- Reset asserted mid-operation discards FIFO contents and any pending DisplayWE.

Optional Feature:
- Macro: ELC3_KB_IRQ_EN.
- When defined:
  - KBSR bit 14 is a read/write interrupt-enable flop.
  - KB_IRQ is registered: KB_IRQ <= IE & (FIFO non-empty), i.e. one cycle after the condition.
- When undefined:
  - KBSR bit 14 reads 0 and writes to it are ignored.
  - KB_IRQ is constant 0 and no IE flop exists.

Test Plan:
- Reset, then read KBSR, DSR and KBDR: all return 16'h0000; DisplayWE=0; Mem_OE=1 only on the SRAM read at 16'h3000.
- Push keys 16'h0041, 16'h0042, 16'h0000: KBSR=16'h8000. Two KBDR reads return 0x0041 then 0x0042; KBSR then reads 16'h0000.
- KB_DEPTH=8: push 9 nonzero keys: KBSR=16'hA000. Read all 8 in order, the 9th is lost. Writing 16'h2000 to KBSR clears overflow.
- Fill the FIFO, then push and read KBDR in the same cycle: the head returns, the new key is appended, and overflow stays 0.
- Pulse DisplayReady, then write 16'h0058 to IO_BASE+6: Data_ToVideo=0x0058, DisplayWE high the next cycle only, DSR=0. A second write before DisplayReady is dropped, Data_ToVideo stays 0x0058.
- With ELC3_KB_IRQ_EN: write KBSR=16'h4000, push a key: KB_IRQ rises one cycle after the push. Draining the FIFO drops KB_IRQ the following cycle. Write 16'hFFFF to HALT_ADDR: DoHalt=1 in the same cycle.
